mdu_iterative: RTL and testbench
================================

// Module: mdu_iterative
// PURPOSE
//  Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core.
//  It sits beside the EX-stage ALU.
//  - Executes MULT/MULTU/DIV/DIVU over several cycles.
//  - Executes MTHI/MTLO in a single cycle.
//  - Raises busy so the hazard unit can stall IF/ID and ID/EX while an operation is in flight.
//  - Supports any operand width, and selects between a single-cycle or shift-add multiplier.
// PARAMETERS
//  WIDTH     32  operand width, and width of each of HI and LO (must be >= 4, even)
//  FAST_MUL  0   1: product computed in one CALC-free step; 0: radix-2 shift-add over WIDTH cycles
// PORTS
//  clk     in   1      rising-edge clock
//  rst     in   1      asynchronous active-low reset
//  start   in   1      request; sampled only while busy=0
//  op      in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved (ignored)
//  a       in   WIDTH  rs operand (dividend / multiplicand / MTHI,MTLO data)
//  b       in   WIDTH  rt operand (divisor / multiplier)
//  cancel  in   1      abort in-flight op (EX flush); no effect when idle
//  busy    out  1      1 while state != IDLE
//  done    out  1      one-cycle pulse; hi/lo hold the new result in the same cycle
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
// BEHAVIOUR
//  Reset (rst=0, any time, including mid-operation)
//   - state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter and operand registers cleared.
//  States: IDLE, CALC, FIX.
//  IDLE
//   - start & op in {4,5}: hi<=a (MTHI) or lo<=a (MTLO) at that edge; no done, no busy; stay IDLE.
//   - start & op in {0..3}: latch |a|,|b| (signed ops) or a,b (unsigned), latch result signs and op; counter<=0.
//     Next state: FIX if (op MULT/MULTU and FAST_MUL=1) or (op DIV/DIVU and b==0); otherwise CALC.
//   - start & op in {6,7}: ignored.
//  CALC
//   - One radix-2 iteration per cycle (shift-add multiply / restoring divide); counter+1.
//   - Leave to FIX on the edge where counter reaches WIDTH-1, i.e. after exactly WIDTH iterations.
//  FIX
//   - Apply sign correction, write hi/lo, set done=1 for one cycle, go to IDLE.
//  Latency (start-sampling edge = edge 0)
//   - done and new hi/lo visible after edge 2 (fast multiply, divide by zero) or edge WIDTH+1 (iterative).
//   - busy=1 from edge 0 until the FIX edge; busy=0 in the done cycle, so a back-to-back start is accepted there.
//  Result rules
//   - MULT/MULTU: {hi,lo} = full 2*WIDTH product, two's complement for MULT.
//   - DIV/DIVU: lo = quotient, hi = remainder.
//   - Signed divide truncates toward zero; remainder takes the dividend's sign.
//   - Divide by zero (signed or unsigned): lo = all ones, hi = a.
//   - Signed overflow (a = -2^(WIDTH-1), b = -1): lo = -2^(WIDTH-1), hi = 0.
//  Boundary conditions
//   - start while busy=1: ignored, no queueing.
//   - cancel in CALC/FIX: go to IDLE at the next edge; hi/lo keep their pre-op values; no done.
//   - cancel together with start in IDLE: start wins.
//   - Operands are latched at accept; later changes to a/b have no effect on the result.
// TESTING (WIDTH=32 unless stated)
//  1. rst low mid-CALC of DIV -> busy=0, done=0, hi=lo=0 immediately; no done pulse after rst rises.
//  2. MULT a=-3, b=7, FAST_MUL=0 -> done exactly 33 cycles after the start edge; hi=FFFFFFFF, lo=FFFFFFEB.
//  3. MULTU a=FFFFFFFF, b=FFFFFFFF, FAST_MUL=1 -> done 2 cycles after start; hi=FFFFFFFE, lo=00000001.
//  4. DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//     DIVU a=7, b=0 -> done at edge 2; lo=FFFFFFFF, hi=00000007.
//  5. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
//     WIDTH=8: DIVU a=200, b=7 -> lo=28, hi=4, done at edge 9.
//  6. MTHI 1234 then DIVU started; start pulses while busy, then cancel at iteration 10
//     -> extra starts ignored; no done; hi=1234 and lo unchanged afterwards.

Source files
------------

// File: rtl/mdu_iterative.sv
// Multiply/divide unit with HI/LO: MULT/DIV in WIDTH+1 cycles (2 for fast multiply or divide by zero), MTHI/MTLO at once.
// busy holds off new requests; starts seen while busy are dropped, and cancel aborts without touching hi/lo.
module mdu_iterative #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               isDiv;
  logic               negLo;
  logic               negHi;
  logic               fixWait;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   accHi;
  logic [WIDTH-1:0]   accLo;

  logic               isMulOp;
  logic               isDivOp;
  logic               sgnOp;
  logic               shortcut;
  logic [WIDTH-1:0]   aAbs;
  logic [WIDTH-1:0]   bAbs;
  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic [WIDTH-1:0]   divSub;
  logic               divGeq;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] negProd;
  logic [WIDTH-1:0]   fixHi;
  logic [WIDTH-1:0]   fixLo;

  assign busy     = (state != IDLE);
  assign isMulOp  = (op == 3'd0) || (op == 3'd1);
  assign isDivOp  = (op == 3'd2) || (op == 3'd3);
  assign sgnOp    = (op == 3'd0) || (op == 3'd2);
  assign shortcut = isMulOp && FAST_MUL;
  assign aAbs     = (sgnOp && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign bAbs     = (sgnOp && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Shift-add multiply keeps the multiplier in accLo and retires one bit per cycle.
  assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
  // Restoring divide: partial remainder in accHi, quotient shifts into accLo.
  assign divShift = {accHi, accLo[WIDTH-1]};
  assign divGeq   = (divShift >= {1'b0, opnd});
  assign divSub   = divShift[WIDTH-1:0] - opnd;
  assign prod     = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, accLo};
  assign negProd  = ~{accHi, accLo} + 1'b1;

  always_comb begin
    fixHi = accHi;
    fixLo = accLo;
    if (isDiv) begin
      fixLo = negLo ? (~accLo + 1'b1) : accLo;
      fixHi = negHi ? (~accHi + 1'b1) : accHi;
    end else if (negLo) begin
      {fixHi, fixLo} = negProd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      isDiv   <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      fixWait <= 1'b0;
      opnd    <= '0;
      accHi   <= '0;
      accLo   <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == 3'd4) begin
              hi <= a;
            end else if (op == 3'd5) begin
              lo <= a;
            end else if (isMulOp || isDivOp) begin
              cnt   <= '0;
              isDiv <= isDivOp;
              if (isDivOp && (b == '0)) begin
                opnd    <= bAbs;
                accHi   <= a;
                accLo   <= '1;
                negLo   <= 1'b0;
                negHi   <= 1'b0;
                fixWait <= 1'b1;
                state   <= FIX;
              end else begin
                opnd    <= isDivOp ? bAbs : aAbs;
                accLo   <= isDivOp ? aAbs : bAbs;
                accHi   <= '0;
                negLo   <= sgnOp && (a[WIDTH-1] ^ b[WIDTH-1]);
                negHi   <= sgnOp && isDivOp && a[WIDTH-1];
                fixWait <= shortcut;
                state   <= shortcut ? FIX : CALC;
              end
            end
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            if (isDiv) begin
              accHi <= divGeq ? divSub : divShift[WIDTH-1:0];
              accLo <= {accLo[WIDTH-2:0], divGeq};
            end else begin
              accHi <= mulSum[WIDTH:1];
              accLo <= {mulSum[0], accLo[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) state <= FIX;
          end
        end
        FIX: begin
          if (cancel) begin
            state <= IDLE;
          end else if (fixWait) begin
            // Shortcut ops spend one extra FIX cycle; the fast product is registered here.
            fixWait <= 1'b0;
            if (!isDiv && FAST_MUL) {accHi, accLo} <= prod;
          end else begin
            hi    <= fixHi;
            lo    <= fixLo;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: 32-bit shift-add, 32-bit fast multiply and 8-bit instances.
module tb_mdu_iterative;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cancel = 1'b0;
  logic        startS = 1'b0, startF = 1'b0, start8 = 1'b0;
  logic [2:0]  op = 3'd0, op8 = 3'd0;
  logic [31:0] a = '0, b = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busyS, doneS, busyF, doneF, busy8, done8;
  logic [31:0] hiS, loS, hiF, loF;
  logic [7:0]  hi8, lo8;
  int          checks = 0;
  int          errors = 0;
  int          cyc;

  always #5 clk = ~clk;

  mdu_iterative #(.WIDTH(32), .FAST_MUL(1'b0)) uS (
    .clk(clk), .rst(rst), .start(startS), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busyS), .done(doneS), .hi(hiS), .lo(loS));
  mdu_iterative #(.WIDTH(32), .FAST_MUL(1'b1)) uF (
    .clk(clk), .rst(rst), .start(startF), .op(op), .a(a), .b(b), .cancel(cancel),
    .busy(busyF), .done(doneF), .hi(hiF), .lo(loF));
  mdu_iterative #(.WIDTH(8), .FAST_MUL(1'b0)) u8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .cancel(cancel),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns cycles from the start edge to the first done, 0 if none within limit.
  task automatic waitDone(input int sel, input int limit, output int n);
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if ((sel == 0 && doneS) || (sel == 1 && doneF) || (sel == 2 && done8)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #2;
    chk("reset_s", {30'd0, busyS, doneS, hiS, loS}, 64'd0);
    chk("reset_8", {46'd0, busy8, done8, hi8, lo8}, 64'd0);
    #21 rst = 1'b1;
    tick();

    // MULT -3 * 7, shift-add; operands changed after accept
    op = 3'd0; a = 32'hFFFF_FFFD; b = 32'd7; startS = 1'b1;
    tick();
    startS = 1'b0; a = 32'h1234_5678; b = 32'h0BAD_F00D;
    chk("mult_busy", {63'd0, busyS}, 64'd1);
    waitDone(0, 40, cyc);
    chk("mult_lat", cyc, 33);
    chk("mult_res", {hiS, loS}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("mult_busy_done", {63'd0, busyS}, 64'd0);

    // MULTU max * max, fast multiply
    op = 3'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; startF = 1'b1;
    tick();
    startF = 1'b0;
    waitDone(1, 10, cyc);
    chk("multu_fast_lat", cyc, 2);
    chk("multu_fast_res", {hiF, loF}, 64'hFFFF_FFFE_0000_0001);

    op = 3'd0; a = 32'hFFFF_FFFD; b = 32'd7; startF = 1'b1;
    tick();
    startF = 1'b0;
    waitDone(1, 10, cyc);
    chk("mult_fast_res", {hiF, loF}, 64'hFFFF_FFFF_FFFF_FFEB);

    // DIV -7 / 2
    op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2; startS = 1'b1;
    tick();
    startS = 1'b0;
    waitDone(0, 40, cyc);
    chk("div_lat", cyc, 33);
    chk("div_res", {hiS, loS}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIVU 7 / 0
    op = 3'd3; a = 32'd7; b = 32'd0; startS = 1'b1;
    tick();
    startS = 1'b0;
    waitDone(0, 10, cyc);
    chk("divu0_lat", cyc, 2);
    chk("divu0_res", {hiS, loS}, 64'h0000_0007_FFFF_FFFF);

    // DIV -7 / 0: hi keeps raw dividend
    op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd0; startS = 1'b1;
    tick();
    startS = 1'b0;
    waitDone(0, 10, cyc);
    chk("div0_res", {hiS, loS}, 64'hFFFF_FFF9_FFFF_FFFF);

    // Signed overflow
    op = 3'd2; a = 32'h8000_0000; b = 32'hFFFF_FFFF; startS = 1'b1;
    tick();
    startS = 1'b0;
    waitDone(0, 40, cyc);
    chk("div_ovf_res", {hiS, loS}, 64'h0000_0000_8000_0000);

    // WIDTH=8 DIVU 200 / 7, then back-to-back 100 / 9 in the done cycle
    op8 = 3'd3; a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    waitDone(2, 20, cyc);
    chk("divu8_lat", cyc, 9);
    chk("divu8_res", {48'd0, hi8, lo8}, {48'd0, 8'd4, 8'd28});
    a8 = 8'd100; b8 = 8'd9; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    waitDone(2, 20, cyc);
    chk("b2b_lat", cyc, 9);
    chk("b2b_res", {48'd0, hi8, lo8}, {48'd0, 8'd1, 8'd11});

    // cancel together with start in IDLE: start wins
    a8 = 8'd50; b8 = 8'd5; start8 = 1'b1; cancel = 1'b1;
    tick();
    start8 = 1'b0; cancel = 1'b0;
    chk("cancel_start_busy", {63'd0, busy8}, 64'd1);
    waitDone(2, 20, cyc);
    chk("cancel_start_res", {48'd0, hi8, lo8}, {48'd0, 8'd0, 8'd10});

    // Reserved op ignored
    op = 3'd6; a = 32'h5555_5555; startS = 1'b1;
    tick();
    startS = 1'b0;
    chk("rsvd_ignored", {31'd0, busyS, hiS}, 64'd0);

    // MTHI, then DIVU with ignored starts and cancel mid-CALC
    op = 3'd4; a = 32'h0000_1234; startS = 1'b1;
    tick();
    startS = 1'b0;
    chk("mthi", {30'd0, busyS, doneS, hiS}, 64'h0000_0000_0000_1234);
    op = 3'd3; a = 32'd100; b = 32'd3; startS = 1'b1;
    tick();
    op = 3'd5; a = 32'hDEAD_BEEF;
    for (int i = 0; i < 9; i++) begin
      startS = i[0];
      tick();
    end
    startS = 1'b0; cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", {63'd0, busyS}, 64'd0);
    waitDone(0, 40, cyc);
    chk("cancel_no_done", cyc, 0);
    chk("cancel_hilo", {hiS, loS}, 64'h0000_1234_8000_0000);

    // Async reset mid-CALC of DIV
    op = 3'd2; a = 32'd1000; b = 32'd7; startS = 1'b1;
    tick();
    startS = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_mid", {30'd0, busyS, doneS, hiS, loS}, 64'd0);
    #10 rst = 1'b1;
    waitDone(0, 40, cyc);
    chk("rst_no_done", cyc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
